// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register pending bits, a post-reset clearing sweep and stall generation.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NRD   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  input  logic [NRD-1:0]       re,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rpend,
  output logic                 stall,
  output logic                 ready,
  output logic [AW:0]          pend_cnt
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [AW:0]      r_cnt;
  logic             r_ready;

  logic             w_sweep;
  logic             w_run;
  logic             w_wr_en;
  logic             w_set;
  logic             w_clr;
  logic             w_inc;
  logic             w_dec;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [AW:0]      w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_idx == AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
  end

  always_comb begin
    w_sweep = 1'b0;
    w_run   = 1'b0;
    case (r_state)
      ST_INIT: w_sweep = 1'b1;
      ST_RUN:  w_run   = 1'b1;
      default: ;
    endcase
  end

  // Set and clear evaluated together; a new producer supersedes a same-cycle writeback.
  always_comb begin
    w_wr_en    = w_run & we & (wa != '0);
    w_set      = w_run & issue_en & (issue_addr != '0);
    w_clr      = w_wr_en & r_pend[wa];
    w_pend_nxt = r_pend;
    if (w_clr) w_pend_nxt[wa] = 1'b0;
    if (w_set) w_pend_nxt[issue_addr] = 1'b1;
    w_inc      = w_set & ~r_pend[issue_addr];
    w_dec      = w_clr & ~(w_set & (issue_addr == wa));
    w_cnt_nxt  = r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= AW'(1);
      r_pend  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_sweep) r_idx <= r_idx + AW'(1);
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == ST_RUN);
    end
  end

  // Array storage is cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_sweep)      r_rf[r_idx] <= '0;
      else if (w_wr_en) r_rf[wa]    <= wd;
    end
  end

  always_comb begin
    logic [AW-1:0] w_ra;
    rd    = '0;
    rpend = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra = ra[i*AW +: AW];
      if (w_run && w_ra != '0) begin
        rd[i*WIDTH +: WIDTH] = r_rf[w_ra];
        rpend[i]             = r_pend[w_ra];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && wa == w_ra) begin
          rd[i*WIDTH +: WIDTH] = wd;
          rpend[i]             = 1'b0;
        end
`endif
      end
    end
  end

  assign stall    = |(re & rpend);
  assign ready    = r_ready;
  assign pend_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized plus directed bench for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 2;
  localparam int unsigned DEPTH = 2 ** AW;

  logic                 clk;
  logic                 reset;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic                 issue_en;
  logic [AW-1:0]        issue_addr;
  logic [NRD-1:0]       re;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic [NRD-1:0]       rpend;
  logic                 stall;
  logic                 ready;
  logic [AW:0]          pend_cnt;

  regfile_scoreboard #(.WIDTH(WIDTH), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .issue_en(issue_en), .issue_addr(issue_addr), .re(re), .ra(ra),
    .rd(rd), .rpend(rpend), .stall(stall), .ready(ready), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [WIDTH-1:0] m_rf   [DEPTH];
  bit               m_pend [DEPTH];
  bit               m_ready;
  bit               m_valid = 0;
  int               m_low_edges;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_pend[i] ? 1 : 0;
    return c;
  endfunction

  task automatic check_outputs();
    logic [NRD*WIDTH-1:0] e_rd;
    logic [NRD-1:0]       e_rp;
    int                   a;
    e_rd = '0;
    e_rp = '0;
    for (int i = 0; i < NRD; i++) begin
      a = int'(ra[i*AW +: AW]);
      if (m_ready && a != 0) begin
        e_rd[i*WIDTH +: WIDTH] = m_rf[a];
        e_rp[i]                = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (we && int'(wa) == a) begin
          e_rd[i*WIDTH +: WIDTH] = wd;
          e_rp[i]                = 1'b0;
        end
`endif
      end
    end
    check("ready", 64'(ready), 64'(m_ready));
    check("pend_cnt", 64'(pend_cnt), 64'(model_count()));
    check("rd", 64'(rd), 64'(e_rd));
    check("rpend", 64'(rpend), 64'(e_rp));
    check("stall", 64'(stall), 64'(|(re & e_rp)));
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_pend[i] = 0;
        m_rf[i]   = '0;
      end
      m_ready     = 0;
      m_low_edges = 0;
      m_valid     = 1;
    end else if (!m_ready) begin
      m_low_edges++;
      if (m_low_edges == DEPTH - 1) m_ready = 1;
    end else begin
      if (we && wa != 0) begin
        m_rf[wa]   = wd;
        m_pend[wa] = 0;
      end
      if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1;
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1 time unit later, model advanced at the rising edge.
  task automatic step();
    #1;
    if (m_valid) check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; we = 0; wa = '0; wd = '0;
    issue_en = 0; issue_addr = '0; re = '0; ra = '0;
  endtask

  task automatic issue(input int a);
    idle(); issue_en = 1; issue_addr = AW'(a); step();
  endtask

  task automatic write(input int a, input logic [WIDTH-1:0] d);
    idle(); we = 1; wa = AW'(a); wd = d; step();
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    repeat (3) step();

    // Sweep with write/issue attempts that must be ignored
    idle();
    we = 1; wa = AW'(5); wd = 32'hA5A5A5A5; issue_en = 1; issue_addr = AW'(5);
    for (int e = 1; e <= DEPTH - 1; e++) begin
      #1;
      check("ready_during_sweep", 64'(ready), 64'(0));
      step();
    end
    idle();
    ra = {AW'(5), AW'(17)};
    #1;
    check("ready_after_31", 64'(ready), 64'(1));
    check("init_pend_cnt", 64'(pend_cnt), 64'(0));
    check("r17_r5_zero", 64'(rd), 64'(0));
    step();

    // Basic scoreboard
    issue(8);
    idle(); ra = {AW'(0), AW'(8)}; re = 2'b01;
    #1;
    check("r8_rpend", 64'(rpend[0]), 64'(1));
    check("r8_stall", 64'(stall), 64'(1));
    check("r8_cnt", 64'(pend_cnt), 64'(1));
    step();
    write(8, 32'hDEADBEEF);
    idle(); ra = {AW'(0), AW'(8)}; re = 2'b01;
    #1;
    check("r8_data", 64'(rd[WIDTH-1:0]), 64'(32'hDEADBEEF));
    check("r8_clear_stall", 64'(stall), 64'(0));
    check("r8_clear_cnt", 64'(pend_cnt), 64'(0));
    step();

    // Simultaneous set and clear
    issue(3);
    idle(); we = 1; wa = AW'(3); wd = 32'h11; issue_en = 1; issue_addr = AW'(3); step();
    idle(); ra = {AW'(0), AW'(3)};
    #1;
    check("r3_still_pend", 64'(rpend[0]), 64'(1));
    check("r3_cnt_same", 64'(pend_cnt), 64'(1));
    check("r3_data", 64'(rd[WIDTH-1:0]), 64'(32'h11));
    step();
    idle(); we = 1; wa = AW'(3); wd = 32'h22; issue_en = 1; issue_addr = AW'(4); step();
    idle(); ra = {AW'(4), AW'(3)};
    #1;
    check("swap_cnt", 64'(pend_cnt), 64'(1));
    check("swap_rpend", 64'(rpend), 64'(2'b10));
    step();
    write(4, 32'h44);

    // Register zero
    idle(); we = 1; wa = '0; wd = 32'hFFFFFFFF; issue_en = 1; issue_addr = '0; step();
    idle(); re = 2'b11;
    #1;
    check("r0_cnt", 64'(pend_cnt), 64'(0));
    check("r0_read", 64'({rpend, rd}), 64'(0));
    step();

    // Bypass behaviour on port 1
    issue(9);
    idle(); we = 1; wa = AW'(9); wd = 32'h1234; ra = {AW'(9), AW'(0)}; re = 2'b10;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rd1", 64'(rd[WIDTH +: WIDTH]), 64'(32'h1234));
    check("byp_rpend1", 64'(rpend[1]), 64'(0));
`else
    check("byp_rd1", 64'(rd[WIDTH +: WIDTH]), 64'(0));
    check("byp_rpend1", 64'(rpend[1]), 64'(1));
`endif
    step();

    // Reset mid-operation with five pending
    for (int a = 10; a < 15; a++) issue(a);
    idle();
    #1;
    check("pre_reset_cnt", 64'(pend_cnt), 64'(5));
    reset = 1; step();
    idle();
    #1;
    check("post_reset_cnt", 64'(pend_cnt), 64'(0));
    check("post_reset_ready", 64'(ready), 64'(0));
    repeat (DEPTH - 1) step();
    idle(); ra = {AW'(0), AW'(8)};
    #1;
    check("r8_after_resweep", 64'(rd[WIDTH-1:0]), 64'(0));
    check("ready_resweep", 64'(ready), 64'(1));
    step();

    // Random traffic, addresses biased to a small window for collisions
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 799) == 0);
      we         = 1'($urandom_range(0, 1));
      wa         = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 6));
      wd         = $urandom;
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 6));
      re         = NRD'($urandom_range(0, 3));
      ra         = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, DEPTH - 1))};
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-read-port register file with a per-register pending (scoreboard) bit. It is the next-generation register file for the MIPS multicycle/pipelined datapath. After reset, a sequential sweep clears the array one entry per cycle. Issue/writeback tracking gives the control unit a per-port hazard flag and a stall signal.

Parameters:
WIDTH, 32, data width of each register
AW, 5, address width; DEPTH = 2**AW entries, entry 0 hardwired to zero
NRD, 2, number of combinational read ports (1..4)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
we  input  1  writeback enable
wa  input  AW  writeback address
wd  input  WIDTH  writeback data
issue_en  input  1  marks issue_addr as pending (new in-flight producer)
issue_addr  input  AW  destination register of issuing instruction
re  input  NRD  per-port read-enable (participates in stall)
ra  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd  output  NRD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
rpend  output  NRD  port i source register still pending
stall  output  1  OR over i of (re[i] & rpend[i])
ready  output  1  init sweep done, block accepting operations
pend_cnt  output  AW+1  number of pending registers

Behaviour:
- Reset (sampled at clk edge):
  - all pending bits <= 0, pend_cnt <= 0, ready <= 0, sweep index <= 1, FSM <= INIT.
  - Register contents are not reset directly; the sweep clears them.
  - Reset asserted mid-operation has the same effect and restarts the sweep.
- FSM INIT:
  - Each edge with reset=0 writes 0 to entry idx, then idx <= idx+1.
  - The edge that clears entry DEPTH-1 moves FSM to RUN and sets ready <= 1.
  - ready therefore rises after exactly DEPTH-1 edges with reset low (31 for AW=5).
  - In INIT: we and issue_en are ignored; rd = 0, rpend = 0, stall = 0.
- FSM RUN: no exit except reset.
- Write: if we and wa != 0, rf[wa] <= wd at the edge. Writes to entry 0 are discarded.
- Scoreboard update at each RUN edge, evaluated for clear and set together:
  - clear: we & wa != 0 & pending[wa] -> pending[wa] <= 0.
  - set: issue_en & issue_addr != 0 -> pending[issue_addr] <= 1.
  - Same address hit by both clear and set in one cycle: set wins (a new producer supersedes); final bit = 1.
  - Issue to an already-pending register: bit stays 1, no count change.
  - Write to a non-pending register: data written, scoreboard unchanged.
  - issue_addr = 0 is ignored; entry 0 is never pending.
- pend_cnt: registered, equals the population count of pending bits after each edge.
  - Increments by 1 only on a 0->1 transition and decrements by 1 only on a 1->0 transition.
  - Simultaneous set of one register and clear of a different one leaves the count unchanged.
  - Maximum value is DEPTH-1; no wrap.
- Read port i (combinational):
  - ra_i = 0 -> rd_i = 0, rpend_i = 0.
  - Otherwise rd_i = rf[ra_i] and rpend_i = pending[ra_i], subject to the optional bypass below.
- stall: combinational from rpend and re; 0 whenever ready = 0.
- Latency: write visible on read ports the cycle after the write edge (without the optional bypass). Pending set/clear visible the cycle after its edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, when we & wa != 0 & wa == ra_i, rd_i = wd and rpend_i = 0 in the same cycle. This is write-through forwarding.
  - If the same cycle also issues to that register, rpend_i is still 0 for this cycle and becomes 1 next cycle.
- Undefined: no forwarding. rd_i shows the old value and rpend_i shows the old pending bit until the edge.

Test Plan:
- Reset sweep: AW=5, hold reset 3 cycles, release -> ready=0 for 30 edges and ready=1 after the 31st edge. Read r17 after ready -> rd=0. Issue/write attempted during INIT -> pend_cnt stays 0, r5 still reads 0.
- Basic scoreboard: issue r8; next cycle ra0=8, re=01 -> rpend[0]=1, stall=1, pend_cnt=1. Write r8=0xDEADBEEF -> next cycle rd0=0xDEADBEEF, rpend=0, stall=0, pend_cnt=0.
- Simultaneous events: r3 pending; same cycle we r3=0x11 plus issue r3 -> r3 remains pending, pend_cnt unchanged, rd=0x11. Same cycle issue r4 and write pending r3 -> pend_cnt unchanged, r4 pending, r3 cleared.
- Register 0: issue r0 and write r0=0xFFFFFFFF -> pend_cnt=0; ra=0 reads 0 with rpend=0.
- Bypass (REGFILE_BYPASS_EN): r9 pending, write r9=0x1234 with ra1=9 -> same cycle rd1=0x1234, rpend[1]=0. Without the macro -> old value and rpend[1]=1 that cycle.
- Reset mid-operation: pend_cnt=5, assert reset one cycle -> pend_cnt=0, ready=0, sweep restarts, previously written r8 reads 0 after ready.
